// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and default sizing for the round-robin grant controller
package arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int DEF_NUM_REQ  = 8;
    localparam int DEF_MAX_HOLD = 15;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority selector, first set bit of req at or above ptr, wrapping
module rr_pick #(
    parameter int NUM_REQ = 8
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      rot_idx;
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req[IW'(i) + ptr];
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) rot_idx = IW'(i);
    end
    // NUM_REQ is a power of two, so the IW-bit add un-rotates modulo NUM_REQ
    assign idx  = rot_idx + ptr;
    assign any  = |req;
    assign pick = any ? (NUM_REQ'(1) << idx) : '0;
endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: registered round-robin grant with multi-cycle ownership and hold limit
// The owner's release input is named rel because release is a reserved word.
module rr_grant_ctrl
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       rel,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    state_t             state, state_nx;
    logic [IW-1:0]      ptr, ptr_nx, gnt_id_nx, pick_idx;
    logic [NUM_REQ-1:0] gnt_nx, pick;
    logic [HW-1:0]      hold_cnt, hold_nx;
    logic               timeout_nx, pick_any;
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_nx;
            gnt       <= gnt_nx;
            gnt_valid <= |gnt_nx;
            gnt_id    <= gnt_id_nx;
            timeout   <= timeout_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        hold_nx    = hold_cnt;
        timeout_nx = 1'b0;
        if (state == IDLE) begin
            if (en && pick_any) begin
                state_nx  = BUSY;
                gnt_nx    = pick;
                gnt_id_nx = pick_idx;
                hold_nx   = '0;
            end
        end else if (!en || rel || !req[gnt_id] || hold_cnt == HW'(MAX_HOLD - 1)) begin
            state_nx   = IDLE;
            gnt_nx     = '0;
            gnt_id_nx  = '0;
            // a disable freezes the rotation; every other ending advances past the owner
            ptr_nx     = en ? gnt_id + IW'(1) : ptr;
            timeout_nx = en && !rel && req[gnt_id];
        end else begin
            hold_nx = hold_cnt + HW'(1);
        end
    end
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed plan plus randomized traffic against an ownership-level model
module tb_rr_grant_ctrl;
    localparam int N  = 8;
    localparam int MH = 4;
    logic       clock = 1'b0, reset_n = 1'b0, en = 1'b0, rel = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] gnt;
    logic       gnt_valid, timeout;
    logic [2:0] gnt_id;
    int checks = 0, errors = 0;
    int m_owner = -1, m_ptr = 0, m_cnt = 0;
    bit m_to = 1'b0;
    logic [7:0] r;
    bit e, rl;

    always #5 clock = ~clock;

    rr_grant_ctrl #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ownership-level model: who owns, for how many cycles, and where the search starts
    task automatic model_step(bit me, logic [7:0] mr, bit mrl);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (me)
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && mr[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_cnt   = 1;
                    end
        end else if (!me) begin
            m_owner = -1;
        end else if (mrl || !mr[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_cnt == MH) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_to    = 1'b0;
    endtask

    task automatic compare_model();
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check("model.gnt", 32'(gnt), 32'(eg));
        check("model.gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 1 : 0);
        check("model.gnt_id", 32'(gnt_id), (m_owner < 0) ? 0 : m_owner);
        check("model.timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic cyc(bit ce, logic [7:0] cr, bit crl);
        en  = ce;
        req = cr;
        rel = crl;
        @(posedge clock);
        model_step(ce, cr, crl);
        #1;
        compare_model();
    endtask

    task automatic lit(string name, logic [7:0] g, logic [2:0] id, bit to);
        check({name, ".gnt"}, 32'(gnt), 32'(g));
        check({name, ".gnt_id"}, 32'(gnt_id), 32'(id));
        check({name, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    // asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset.gnt_valid", 32'(gnt_valid), 0);
        compare_model();
        @(posedge clock);
        #1;
        compare_model();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        en  = 1'b1;
        req = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        lit("reset", 8'h00, 3'd0, 1'b0);
        check("reset.gnt_valid", 32'(gnt_valid), 0);
        reset_n = 1'b1;
        model_reset();
        cyc(1, 8'h01, 0);
        lit("first_grant", 8'h01, 3'd0, 1'b0);
        cyc(1, 8'h01, 1);
        do_reset();
        cyc(1, 8'h90, 0);
        lit("grant4", 8'h10, 3'd4, 1'b0);
        cyc(1, 8'h90, 1);
        lit("release_gap", 8'h00, 3'd0, 1'b0);
        cyc(1, 8'h90, 0);
        lit("grant7", 8'h80, 3'd7, 1'b0);
        cyc(1, 8'h81, 1);
        lit("wrap_gap", 8'h00, 3'd0, 1'b0);
        cyc(1, 8'h81, 0);
        lit("wrap_grant0", 8'h01, 3'd0, 1'b0);
        cyc(1, 8'h04, 1);
        for (int k = 0; k < MH; k++) begin
            cyc(1, 8'h04, 0);
            lit("hold2", 8'h04, 3'd2, 1'b0);
        end
        cyc(1, 8'h04, 0);
        lit("timeout", 8'h00, 3'd0, 1'b1);
        cyc(1, 8'h0C, 0);
        lit("after_timeout", 8'h08, 3'd3, 1'b0);
        cyc(1, 8'h20, 1);
        cyc(1, 8'h20, 0);
        lit("grant5", 8'h20, 3'd5, 1'b0);
        cyc(1, 8'h20, 0);
        cyc(0, 8'h20, 0);
        lit("en_drop", 8'h00, 3'd0, 1'b0);
        cyc(1, 8'h60, 0);
        lit("en_regrant", 8'h20, 3'd5, 1'b0);
        cyc(1, 8'h08, 1);
        cyc(1, 8'h08, 0);
        lit("grant3", 8'h08, 3'd3, 1'b0);
        do_reset();
        cyc(1, 8'h18, 0);
        lit("post_reset", 8'h08, 3'd3, 1'b0);
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            e  = ($urandom_range(0, 15) != 0);
            rl = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc(e, r, rl);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
